// File: rtl/pc_fetch_reg.sv
// Program counter register with a req/ack instruction-fetch sequencer.
// Optional macro PC_ALIGN_CHECK_EN adds a misalign pulse that suppresses fetches of unaligned PCs.
module pc_fetch_reg #(
  parameter int                 ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] nextaddr,
  input  logic              pc_we,
  input  logic              fetch_start,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [31:0]       instr,
  output logic              instr_valid,
`ifdef PC_ALIGN_CHECK_EN
  output logic              misalign,
`endif
  output logic              busy
);

  typedef enum logic [0:0] {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] pc_r, pc_s;
  logic [ADDR_W-1:0] pend_addr_r, pend_addr_s;
  logic              pending_r, pending_s;
  logic [31:0]       instr_r, instr_s;
  logic              instr_valid_r, instr_valid_s;
  logic              misalign_r, misalign_s;

  // Next-state, PC update and fetch-result logic.
  always_comb begin
    state_s       = state_r;
    pc_s          = pc_r;
    pend_addr_s   = pend_addr_r;
    pending_s     = pending_r;
    instr_s       = instr_r;
    instr_valid_s = 1'b0;
    misalign_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (pc_we) begin
          pc_s = nextaddr;
        end else begin
          pc_s = pc_r;
        end
        if (fetch_start) begin
`ifdef PC_ALIGN_CHECK_EN
          if (pc_s[1:0] != 2'b00) begin
            misalign_s = 1'b1;
          end else begin
            state_s = REQ;
          end
`else
          state_s = REQ;
`endif
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        if (imem_ack) begin
          instr_s       = imem_rdata;
          instr_valid_s = 1'b1;
          state_s       = IDLE;
          pending_s     = 1'b0;
          // A same-cycle write beats any address parked during the fetch.
          if (pc_we) begin
            pc_s = nextaddr;
          end else if (pending_r) begin
            pc_s = pend_addr_r;
          end else begin
            pc_s = pc_r;
          end
        end else if (pc_we) begin
          pend_addr_s = nextaddr;
          pending_s   = 1'b1;
        end else begin
          state_s = REQ;
        end
      end
      default: begin
        state_s   = IDLE;
        pending_s = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      pc_r          <= RESET_PC;
      pend_addr_r   <= '0;
      pending_r     <= 1'b0;
      instr_r       <= 32'h0000_0000;
      instr_valid_r <= 1'b0;
      misalign_r    <= 1'b0;
    end else begin
      state_r       <= state_s;
      pc_r          <= pc_s;
      pend_addr_r   <= pend_addr_s;
      pending_r     <= pending_s;
      instr_r       <= instr_s;
      instr_valid_r <= instr_valid_s;
      misalign_r    <= misalign_s;
    end
  end

  assign imem_req    = (state_r == REQ);
  assign busy        = (state_r == REQ);
  assign imem_addr   = pc_r;
  assign pc          = pc_r;
  assign pc_plus4    = pc_r + ADDR_W'(3'd4);
  assign instr       = instr_r;
  assign instr_valid = instr_valid_r;
`ifdef PC_ALIGN_CHECK_EN
  assign misalign    = misalign_r;
`else
  logic unused_s;
  assign unused_s = misalign_r ^ misalign_s;
`endif

endmodule

// File: tb/tb_pc_fetch_reg.sv
// Self-checking bench for pc_fetch_reg: directed test-plan scenarios plus randomized
// traffic compared every cycle against a transaction-level model of the fetch unit.
module tb_pc_fetch_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] nextaddr = 32'h0;
  logic        pc_we = 1'b0;
  logic        fetch_start = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] pc, pc_plus4, instr;
  logic        instr_valid, busy;
`ifdef PC_ALIGN_CHECK_EN
  logic        misalign;
`endif

  int passed = 0;
  int total  = 0;
  bit chk_en = 1'b0;

  pc_fetch_reg #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .nextaddr(nextaddr), .pc_we(pc_we),
    .fetch_start(fetch_start), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc(pc), .pc_plus4(pc_plus4),
    .instr(instr), .instr_valid(instr_valid),
`ifdef PC_ALIGN_CHECK_EN
    .misalign(misalign),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Transaction-level model: is a fetch in flight, which PC is architecturally current,
  // and which redirect (if any) is waiting for the fetch to finish.
  logic [31:0] m_pc = 32'h0, m_instr = 32'h0, m_pend = 32'h0;
  bit          m_fetching = 1'b0, m_has_pend = 1'b0, m_valid = 1'b0, m_misalign = 1'b0;
  bit          align_check;
`ifdef PC_ALIGN_CHECK_EN
  assign align_check = 1'b1;
`else
  assign align_check = 1'b0;
`endif

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc <= 32'h0; m_instr <= 32'h0; m_fetching <= 1'b0;
      m_has_pend <= 1'b0; m_valid <= 1'b0; m_misalign <= 1'b0;
    end else begin
      m_valid <= 1'b0;
      m_misalign <= 1'b0;
      if (!m_fetching) begin
        logic [31:0] eff;
        eff = pc_we ? nextaddr : m_pc;
        m_pc <= eff;
        if (fetch_start) begin
          if (align_check && (eff % 4 != 0)) m_misalign <= 1'b1;
          else m_fetching <= 1'b1;
        end
      end else if (imem_ack) begin
        m_instr <= imem_rdata;
        m_valid <= 1'b1;
        m_fetching <= 1'b0;
        m_has_pend <= 1'b0;
        if (pc_we) m_pc <= nextaddr;
        else if (m_has_pend) m_pc <= m_pend;
      end else if (pc_we) begin
        m_pend <= nextaddr;
        m_has_pend <= 1'b1;
      end
    end
  end

  // Per-cycle comparison against the model, sampled 1 time unit after the rising edge.
  bit prev_valid = 1'b0;
  always begin
    @(posedge clk);
    #1;
    if (chk_en) begin
      chk("pc", pc, m_pc);
      chk("pc_plus4", pc_plus4, m_pc + 32'd4);
      chk("imem_addr", imem_addr, m_pc);
      chk("imem_req", {31'd0, imem_req}, {31'd0, m_fetching});
      chk("busy", {31'd0, busy}, {31'd0, m_fetching});
      chk("instr", instr, m_instr);
      chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
      chk("valid_not_back_to_back", {31'd0, prev_valid & instr_valid}, 32'd0);
`ifdef PC_ALIGN_CHECK_EN
      chk("misalign", {31'd0, misalign}, {31'd0, m_misalign});
`endif
    end
    prev_valid = instr_valid;
  end

  // Apply one cycle of inputs at a falling edge and advance to the next falling edge.
  task automatic drive(input bit we, input logic [31:0] na, input bit fs,
                       input bit ack, input logic [31:0] rd);
    pc_we = we; nextaddr = na; fetch_start = fs; imem_ack = ack; imem_rdata = rd;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_pc", pc, 32'h0);
    chk("rst_pc_plus4", pc_plus4, 32'h4);
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_instr", instr, 32'h0);

    // Load 0x40, fetch, ack on the third REQ cycle.
    drive(1, 32'h40, 0, 0, 32'h0);
    chk("load_pc", pc, 32'h40);
    chk("model_load_pc", m_pc, 32'h40);
    drive(0, 32'h0, 1, 0, 32'h0);
    chk("req_up", {31'd0, imem_req}, 32'd1);
    chk("req_addr", imem_addr, 32'h40);
    drive(0, 32'h0, 0, 0, 32'h0);
    drive(0, 32'h0, 0, 0, 32'h0);
    chk("req_addr_held", imem_addr, 32'h40);
    drive(0, 32'h0, 0, 1, 32'h2008_0005);
    chk("fetched_instr", instr, 32'h2008_0005);
    chk("model_instr", m_instr, 32'h2008_0005);
    chk("valid_pulse", {31'd0, instr_valid}, 32'd1);
    chk("busy_low", {31'd0, busy}, 32'd0);
    drive(0, 32'h0, 0, 0, 32'h0);
    chk("valid_drop", {31'd0, instr_valid}, 32'd0);
    chk("instr_hold", instr, 32'h2008_0005);

    // Redirect during REQ is parked until the ack.
    drive(0, 32'h0, 1, 0, 32'h0);
    drive(1, 32'h100, 0, 0, 32'h0);
    chk("pend_addr_stable", imem_addr, 32'h40);
    drive(0, 32'h0, 0, 0, 32'h0);
    chk("pend_pc_stable", pc, 32'h40);
    drive(0, 32'h0, 0, 1, 32'h1111_2222);
    chk("pend_applied", pc, 32'h100);

    // Same-cycle write beats an older pending redirect, and pending clears.
    drive(0, 32'h0, 1, 0, 32'h0);
    drive(1, 32'h300, 0, 0, 32'h0);
    drive(1, 32'h200, 0, 1, 32'h3333_4444);
    chk("ack_we_wins", pc, 32'h200);
    drive(0, 32'h0, 1, 0, 32'h0);
    drive(0, 32'h0, 0, 1, 32'h5555_6666);
    chk("pending_cleared", pc, 32'h200);

    // Wrap of pc+4 and a fetch at the top of memory.
    drive(1, 32'hFFFF_FFFC, 0, 0, 32'h0);
    chk("plus4_wrap", pc_plus4, 32'h0);
    drive(0, 32'h0, 1, 0, 32'h0);
    chk("top_addr", imem_addr, 32'hFFFF_FFFC);
    drive(0, 32'h0, 0, 1, 32'hABCD_0123);
    chk("top_instr", instr, 32'hABCD_0123);

    // Unaligned fetch request.
    drive(1, 32'h42, 1, 0, 32'h0);
`ifdef PC_ALIGN_CHECK_EN
    chk("misalign_pulse", {31'd0, misalign}, 32'd1);
    chk("misalign_no_req", {31'd0, imem_req}, 32'd0);
    drive(0, 32'h0, 0, 0, 32'h0);
    chk("misalign_one_cycle", {31'd0, misalign}, 32'd0);
`else
    chk("unaligned_req", {31'd0, imem_req}, 32'd1);
    chk("unaligned_addr", imem_addr, 32'h42);
    drive(0, 32'h0, 0, 1, 32'h7777_8888);
`endif

    // Reset mid-fetch drops the request at once; a late ack is ignored.
    drive(1, 32'h80, 1, 0, 32'h0);
    chk("pre_reset_req", {31'd0, imem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_req_drop", {31'd0, imem_req}, 32'd0);
    chk("async_pc_reset", pc, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 32'h0, 0, 1, 32'hDEAD_BEEF);
    chk("late_ack_ignored", instr, 32'h0);
    chk("late_ack_idle", {31'd0, busy}, 32'd0);

    // Randomized traffic, including occasional resets.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] na;
      na = $urandom;
      if ($urandom_range(0, 3) != 0) na[1:0] = 2'b00;
      rst_n = ($urandom_range(0, 399) != 0);
      drive($urandom_range(0, 3) == 0, na, $urandom_range(0, 2) == 0,
            $urandom_range(0, 2) == 0, $urandom);
    end
    rst_n = 1'b1;
    drive(0, 32'h0, 0, 0, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
